regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_sb_if.sv | 36 +++
 rtl/regfile_bypass_mux.sv | 36 +++
 rtl/regfile_sb.sv | 121 ++++++++++++
 tb/tb_regfile_sb.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  regfile_pkg
//  Shared defaults, index/data types and the x0 constant for the register file.
//  Revision: 1.0
// ============================================================================
package regfile_pkg;

   localparam int REG_DATA_WIDTH_POW = 6;
   localparam int REG_MEM_DEPTH_POW  = 5;

   typedef logic [(1 << REG_DATA_WIDTH_POW)-1:0] reg_data_t;
   typedef logic [REG_MEM_DEPTH_POW-1:0]         reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  regfile_sb_if
//  Read, write-back and issue signals between the pipeline and the register file.
//  Revision: 1.0
// ============================================================================
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 2,
   parameter int DATA_W    = 1 << regfile_pkg::REG_DATA_WIDTH_POW,
   parameter int IDX_W     = regfile_pkg::REG_MEM_DEPTH_POW
);
   logic [NUM_READ-1:0][IDX_W-1:0]   rs_in;
   logic [NUM_READ-1:0][DATA_W-1:0]  reg_data_out;
   logic [NUM_READ-1:0]              busy_out;
   logic [NUM_WRITE-1:0]             wr_en;
   logic [NUM_WRITE-1:0][IDX_W-1:0]  wr_rd_in;
   logic [NUM_WRITE-1:0][DATA_W-1:0] wr_data_in;
   logic                             issue_en;
   logic [IDX_W-1:0]                 issue_rd_in;
   logic [IDX_W:0]                   pending_cnt_out;

   modport master (
      output rs_in, wr_en, wr_rd_in, wr_data_in, issue_en, issue_rd_in,
      input  reg_data_out, busy_out, pending_cnt_out
   );

   modport slave (
      input  rs_in, wr_en, wr_rd_in, wr_data_in, issue_en, issue_rd_in,
      output reg_data_out, busy_out, pending_cnt_out
   );

endinterface
`default_nettype wire

// File: rtl/regfile_bypass_mux.sv
`default_nettype none
// ============================================================================
//  regfile_bypass_mux
//  Selects same-cycle write data for one read index; flags a same-cycle clear.
//  Revision: 1.0
// ============================================================================
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int NUM_WRITE = 2,
   parameter int DATA_W    = 1 << regfile_pkg::REG_DATA_WIDTH_POW,
   parameter int IDX_W     = regfile_pkg::REG_MEM_DEPTH_POW
) (
   input  wire logic [IDX_W-1:0]                 i_rs,
   input  wire logic [DATA_W-1:0]                i_stored,
   input  wire logic [NUM_WRITE-1:0]             i_wr_commit,
   input  wire logic [NUM_WRITE-1:0][IDX_W-1:0]  i_wr_rd,
   input  wire logic [NUM_WRITE-1:0][DATA_W-1:0] i_wr_data,
   output      logic [DATA_W-1:0]                o_data,
   output      logic                             o_cleared
);

   // Ascending scan so the highest-index matching port is the one that sticks.
   always_comb begin
      o_data    = i_stored;
      o_cleared = 1'b0;
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (i_wr_commit[k] && (i_wr_rd[k] == i_rs)) begin
            o_data    = i_wr_data[k];
            o_cleared = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  regfile_sb
//  Multi-port register file with write-to-read bypass and pending scoreboard.
//  Revision: 1.0
// ============================================================================
module regfile_sb #(
   parameter int REG_DATA_WIDTH_POW = regfile_pkg::REG_DATA_WIDTH_POW,
   parameter int REG_MEM_DEPTH_POW  = regfile_pkg::REG_MEM_DEPTH_POW,
   parameter int NUM_READ           = 2,
   parameter int NUM_WRITE          = 2,
   parameter int BYPASS_EN          = 1
) (
   input  wire logic   clk_in,
   input  wire logic   reset,
   regfile_sb_if.slave rf
);
   import regfile_pkg::*;

   localparam int c_DW = 1 << REG_DATA_WIDTH_POW;
   localparam int c_AW = REG_MEM_DEPTH_POW;
   localparam int c_D  = 1 << REG_MEM_DEPTH_POW;

   logic [c_DW-1:0]                 r_regs [c_D];
   logic [c_D-1:0]                  r_pending;
   logic [c_AW:0]                   r_pend_cnt;

   logic [NUM_WRITE-1:0]            w_commit;
   logic [c_D-1:0]                  w_pend_next;
   logic [c_AW:0]                   w_cnt_next;
   logic [NUM_READ-1:0][c_DW-1:0]   w_rd_data;
   logic [NUM_READ-1:0]             w_rd_busy;

   always_comb begin
      w_commit = '0;
      for (int k = 0; k < NUM_WRITE; k++) begin
         w_commit[k] = rf.wr_en[k] && (rf.wr_rd_in[k] != REG_ZERO);
      end
   end

   // Clears first, then the issue set, so a same-cycle issue is the newer producer.
   always_comb begin
      w_pend_next = r_pending;
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (w_commit[k]) begin
            w_pend_next[rf.wr_rd_in[k]] = 1'b0;
         end
      end
      if (rf.issue_en && (rf.issue_rd_in != REG_ZERO)) begin
         w_pend_next[rf.issue_rd_in] = 1'b1;
      end
      w_pend_next[0] = 1'b0;
   end

   always_comb begin
      w_cnt_next = '0;
      for (int i = 0; i < c_D; i++) begin
         w_cnt_next = w_cnt_next + {{c_AW{1'b0}}, w_pend_next[i]};
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         for (int i = 0; i < c_D; i++) begin
            r_regs[i] <= '0;
         end
         r_pending  <= '0;
         r_pend_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_WRITE; k++) begin
            if (w_commit[k]) begin
               r_regs[rf.wr_rd_in[k]] <= rf.wr_data_in[k];
            end
         end
         r_pending  <= w_pend_next;
         r_pend_cnt <= w_cnt_next;
      end
   end

   generate
      for (genvar i = 0; i < NUM_READ; i++) begin : g_read
         logic [c_DW-1:0] w_fwd_data;
         logic            w_fwd_clr;

         regfile_bypass_mux #(
            .NUM_WRITE (NUM_WRITE),
            .DATA_W    (c_DW),
            .IDX_W     (c_AW)
         ) u_bypass (
            .i_rs        (rf.rs_in[i]),
            .i_stored    (r_regs[rf.rs_in[i]]),
            .i_wr_commit (w_commit),
            .i_wr_rd     (rf.wr_rd_in),
            .i_wr_data   (rf.wr_data_in),
            .o_data      (w_fwd_data),
            .o_cleared   (w_fwd_clr)
         );

         if (BYPASS_EN != 0) begin : g_fwd
            assign w_rd_data[i] = (rf.rs_in[i] == REG_ZERO) ? '0 : w_fwd_data;
            assign w_rd_busy[i] = r_pending[rf.rs_in[i]] && !w_fwd_clr;
         end else begin : g_nofwd
            assign w_rd_data[i] = (rf.rs_in[i] == REG_ZERO) ? '0 : r_regs[rf.rs_in[i]];
            assign w_rd_busy[i] = r_pending[rf.rs_in[i]];
         end
      end
   endgenerate

   assign rf.reg_data_out    = w_rd_data;
   assign rf.busy_out        = w_rd_busy;
   assign rf.pending_cnt_out = r_pend_cnt;

`ifdef FORMAL
   always_comb begin
      assert (r_regs[0] == '0);
      assert (r_pending[0] == 1'b0);
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  tb_regfile_sb
//  Directed and random checks of bypassing and non-bypassing register files.
//  Revision: 1.0
// ============================================================================
module tb_regfile_sb;

   localparam int NR = 2;
   localparam int NW = 2;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int D  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   logic [NR-1:0][AW-1:0]  rs;
   logic [NW-1:0]          wen;
   logic [NW-1:0][AW-1:0]  wrd;
   logic [NW-1:0][DW-1:0]  wdat;
   logic                   iss;
   logic [AW-1:0]          ird;

   regfile_sb_if #(.NUM_READ(NR), .NUM_WRITE(NW), .DATA_W(DW), .IDX_W(AW)) if_b1 ();
   regfile_sb_if #(.NUM_READ(NR), .NUM_WRITE(NW), .DATA_W(DW), .IDX_W(AW)) if_b0 ();

   assign if_b1.rs_in       = rs;
   assign if_b1.wr_en       = wen;
   assign if_b1.wr_rd_in    = wrd;
   assign if_b1.wr_data_in  = wdat;
   assign if_b1.issue_en    = iss;
   assign if_b1.issue_rd_in = ird;
   assign if_b0.rs_in       = rs;
   assign if_b0.wr_en       = wen;
   assign if_b0.wr_rd_in    = wrd;
   assign if_b0.wr_data_in  = wdat;
   assign if_b0.issue_en    = iss;
   assign if_b0.issue_rd_in = ird;

   regfile_sb #(.REG_DATA_WIDTH_POW(6), .REG_MEM_DEPTH_POW(5), .NUM_READ(NR),
                .NUM_WRITE(NW), .BYPASS_EN(1)) u_b1 (
      .clk_in (clk),
      .reset  (rst),
      .rf     (if_b1)
   );

   regfile_sb #(.REG_DATA_WIDTH_POW(6), .REG_MEM_DEPTH_POW(5), .NUM_READ(NR),
                .NUM_WRITE(NW), .BYPASS_EN(0)) u_b0 (
      .clk_in (clk),
      .reset  (rst),
      .rf     (if_b0)
   );

   // Reference state: architectural register contents and pending set.
   logic [DW-1:0] m_mem [D];
   logic [D-1:0]  m_pend;
   logic [D-1:0]  m_np;
   bit            chk_en = 1'b0;
   int            n_vec  = 0;
   int            n_err  = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < D; i++) m_mem[i] <= '0;
         m_pend <= '0;
      end else begin
         m_np = m_pend;
         for (int k = 0; k < NW; k++) begin
            if (wen[k] && wrd[k] != 0) begin
               m_mem[wrd[k]] <= wdat[k];
               m_np[wrd[k]] = 1'b0;
            end
         end
         if (iss && ird != 0) m_np[ird] = 1'b1;
         m_pend <= m_np;
      end
   end

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] r, input bit byp);
      logic [DW-1:0] v;
      if (r == 0) return '0;
      v = m_mem[r];
      if (byp)
         for (int k = 0; k < NW; k++)
            if (wen[k] && wrd[k] == r) v = wdat[k];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] r, input bit byp);
      logic b;
      b = (r != 0) && m_pend[r];
      if (byp)
         for (int k = 0; k < NW; k++)
            if (wen[k] && wrd[k] == r) b = 1'b0;
      return b;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int i = 0; i < NR; i++) begin
            check($sformatf("b1 data[%0d]", i), if_b1.reg_data_out[i], exp_data(rs[i], 1'b1));
            check($sformatf("b0 data[%0d]", i), if_b0.reg_data_out[i], exp_data(rs[i], 1'b0));
            check($sformatf("b1 busy[%0d]", i), {63'b0, if_b1.busy_out[i]}, {63'b0, exp_busy(rs[i], 1'b1)});
            check($sformatf("b0 busy[%0d]", i), {63'b0, if_b0.busy_out[i]}, {63'b0, exp_busy(rs[i], 1'b0)});
         end
         check("b1 cnt", {58'b0, if_b1.pending_cnt_out}, 64'($countones(m_pend)));
         check("b0 cnt", {58'b0, if_b0.pending_cnt_out}, 64'($countones(m_pend)));
      end
   end

   task automatic idle();
      wen  = '0;
      wrd  = '0;
      wdat = '0;
      iss  = 1'b0;
      ird  = '0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_idx();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, D - 1));
   endfunction

   initial begin
      rst = 1'b1;
      rs  = '0;
      idle();
      next();
      next();
      rst    = 1'b0;
      chk_en = 1'b1;

      // Reset values
      rs[0] = 5; rs[1] = 31;
      @(negedge clk);
      check("rst data0", if_b1.reg_data_out[0], 64'h0);
      check("rst data1", if_b1.reg_data_out[1], 64'h0);
      check("rst busy",  {62'b0, if_b1.busy_out}, 64'h0);
      check("rst cnt",   {58'b0, if_b0.pending_cnt_out}, 64'h0);
      next();

      // Write x5, bypass vs. registered read
      wen = 2'b01; wrd[0] = 5; wdat[0] = 64'hDEADBEEF;
      @(negedge clk);
      check("x5 bypass", if_b1.reg_data_out[0], 64'hDEADBEEF);
      check("x5 nobyp",  if_b0.reg_data_out[0], 64'h0);
      next();
      idle();
      @(negedge clk);
      check("x5 stored", if_b0.reg_data_out[0], 64'hDEADBEEF);
      next();

      // x0 write dropped
      wen = 2'b01; wrd[0] = 0; wdat[0] = 64'h1234; rs[0] = 0;
      @(negedge clk);
      check("x0 bypass", if_b1.reg_data_out[0], 64'h0);
      next();
      idle();
      @(negedge clk);
      check("x0 stored", if_b0.reg_data_out[0], 64'h0);
      next();

      // Port collision on x7
      wen = 2'b11; wrd[0] = 7; wrd[1] = 7; wdat[0] = 64'hAA; wdat[1] = 64'hBB; rs[0] = 7;
      @(negedge clk);
      check("x7 bypass", if_b1.reg_data_out[0], 64'hBB);
      check("x7 nobyp",  if_b0.reg_data_out[0], 64'h0);
      next();
      idle();
      @(negedge clk);
      check("x7 stored", if_b0.reg_data_out[0], 64'hBB);
      next();

      // Bypass toggle on x3
      wen = 2'b01; wrd[0] = 3; wdat[0] = 64'h55; rs[0] = 3;
      @(negedge clk);
      check("x3 nobyp",  if_b0.reg_data_out[0], 64'h0);
      check("x3 bypass", if_b1.reg_data_out[0], 64'h55);
      next();
      idle();
      @(negedge clk);
      check("x3 stored", if_b0.reg_data_out[0], 64'h55);
      next();

      // Scoreboard on x9
      iss = 1'b1; ird = 9; rs[0] = 9;
      @(negedge clk);
      check("x9 issue same", {63'b0, if_b1.busy_out[0]}, 64'h0);
      next();
      idle();
      @(negedge clk);
      check("x9 busy b1", {63'b0, if_b1.busy_out[0]}, 64'h1);
      check("x9 busy b0", {63'b0, if_b0.busy_out[0]}, 64'h1);
      check("x9 cnt",     {58'b0, if_b1.pending_cnt_out}, 64'h1);
      next();
      wen = 2'b01; wrd[0] = 9; wdat[0] = 64'h1;
      @(negedge clk);
      check("x9 clr b1", {63'b0, if_b1.busy_out[0]}, 64'h0);
      check("x9 clr b0", {63'b0, if_b0.busy_out[0]}, 64'h1);
      next();
      idle();
      @(negedge clk);
      check("x9 cnt0", {58'b0, if_b1.pending_cnt_out}, 64'h0);
      next();
      iss = 1'b1; ird = 9; wen = 2'b01; wrd[0] = 9; wdat[0] = 64'h2;
      next();
      idle();
      @(negedge clk);
      check("x9 set wins", {63'b0, if_b0.busy_out[0]}, 64'h1);
      next();

      // Reset mid-operation
      wen = 2'b01; wrd[0] = 4; wdat[0] = 64'h99; iss = 1'b1; ird = 4;
      next();
      idle(); rs[0] = 4;
      @(negedge clk);
      check("x4 data", if_b0.reg_data_out[0], 64'h99);
      check("x4 cnt",  {58'b0, if_b0.pending_cnt_out}, 64'h2);
      next();
      rst = 1'b1; wen = 2'b01; wrd[0] = 6; wdat[0] = 64'h77; iss = 1'b1; ird = 4;
      next();
      rst = 1'b0; idle(); rs[0] = 4; rs[1] = 6;
      @(negedge clk);
      check("rst2 x4",   if_b1.reg_data_out[0], 64'h0);
      check("rst2 x6",   if_b1.reg_data_out[1], 64'h0);
      check("rst2 busy", {62'b0, if_b0.busy_out}, 64'h0);
      check("rst2 cnt",  {58'b0, if_b1.pending_cnt_out}, 64'h0);
      next();

      // Random traffic, checked every cycle by the compare process
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NR; i++) rs[i] = rnd_idx();
         wen = NW'($urandom_range(0, 3));
         for (int k = 0; k < NW; k++) begin
            wrd[k]  = rnd_idx();
            wdat[k] = {$urandom, $urandom};
         end
         iss = ($urandom_range(0, 1) == 1);
         ird = rnd_idx();
         next();
      end

      chk_en = 1'b0;
      rst    = 1'b0;
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
